target_port: RTL and testbench
==============================

# target_port

Target-side serial bus port, sitting between the shared one-bit bus and a memory-style target. It deserializes a 16-bit address and, for writes, an 8-bit data byte sent LSB-first by the initiator port. It issues the access to the target over a valid/ready handshake. For reads, it serializes the returned byte back onto the same tri-state line.

## Interface
- `RD_TIMEOUT`, default 255: cycles spent in RD_WAIT before a read is answered with 8'hFF; legal range 1–65535.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `bus_data` inout 1: shared serial line; driven only while `bus_data_out_valid`=1, else 'z.
- `bus_data_in_valid` in 1: a valid initiator bit is on `bus_data` this cycle.
- `bus_mode` in 1: 0 = address phase, 1 = data phase.
- `bus_init_rw` in 1: 1 = write, 0 = read; sampled when the 16th address bit arrives.
- `bus_init_ready` in 1: initiator can accept read-data bits.
- `target_ack` out 1: one-cycle pulse when a full address is received.
- `bus_data_out_valid` out 1: this port drives `bus_data` this cycle.
- `target_addr_out` out 16: captured address.
- `target_data_out` out 8: captured write byte.
- `target_rw` out 1: access type of the current request.
- `target_req_valid` out 1: access request to the target.
- `target_ready` in 1: target accepts the request.
- `target_data_in` in 8: read data from the target.
- `target_data_in_valid` in 1: `target_data_in` is valid.

## Operation
- States and transitions:
  - RX_ADDR → RX_DATA when 16 bits are received with rw=1.
  - RX_ADDR → RD_ISSUE when 16 bits are received with rw=0.
  - RX_DATA → WR_ISSUE when 8 bits are received.
  - WR_ISSUE → RX_ADDR when `target_ready`=1.
  - RD_ISSUE → RD_WAIT when `target_ready`=1.
  - RD_WAIT → TX_DATA when `target_data_in_valid`=1 or the timeout expires.
  - TX_DATA → RX_ADDR after 8 bits are sent.
- A bit is accepted only when `bus_data_in_valid`=1, state is RX_ADDR or RX_DATA, and `bus_mode` matches that state (0 for RX_ADDR, 1 for RX_DATA).
- Bit k received in a phase is stored at index k (LSB first). Bit counter is 5 bits wide and clears on every phase change.
- A bit with mismatched `bus_mode` in RX_ADDR is ignored.
- In RX_DATA, an address-mode bit aborts the write. The bit is taken as address bit 0 and state returns to RX_ADDR. No target request is made.
- `target_ack` pulses on the cycle after the 16th address bit, for reads and writes alike.
- WR_ISSUE: `target_req_valid`=1, `target_rw`=1, with address and data held stable until `target_ready`.
- RD_ISSUE: `target_req_valid`=1, `target_rw`=0, held until `target_ready`.
- RD_WAIT:
  - Capture `target_data_in` on `target_data_in_valid`.
  - A 16-bit counter starts at 0 on entry. When it reaches `RD_TIMEOUT` with no valid data, capture 8'hFF.
  - `target_data_in_valid` on the same cycle as the timeout wins over 8'hFF.
- TX_DATA:
  - Bits are driven LSB first, one per cycle, only on cycles where `bus_init_ready`=1.
  - Dropping `bus_init_ready` mid-byte pauses the shift. `bus_data_out_valid` goes low during the pause; there is no bit loss.
- Incoming `bus_data_in_valid` bits are ignored in every state other than RX_ADDR and RX_DATA.

## Timing
- Reset values: state RX_ADDR, counters 0.
- All outputs reset to 0 and are registered: `target_ack`, `bus_data_out_valid`, `target_req_valid`, `target_rw`, `target_addr_out`, `target_data_out`. `bus_data` is 'z.
- Reset asserted mid-operation aborts any transfer on the next edge: line released, request dropped, no `target_ack`.
- Write, bit cycle to request:
  - 16th address bit sampled at edge N → `target_ack`=1 during N+1.
  - 8th data bit sampled at edge M → `target_req_valid`=1 from M+1.
- Request handshake completes at the first edge where `target_req_valid` and `target_ready` are both 1. `target_req_valid` is 0 on the following cycle.
- Read turnaround:
  - Data captured at edge P. If `bus_init_ready`=1, the first bit is driven (`bus_data_out_valid`=1) from P+1.
  - An unstalled byte occupies exactly 8 consecutive cycles.
  - RX_ADDR is re-entered after the 8th bit's cycle.
- Minimum read latency, last address bit to first read bit, is 3 cycles (ISSUE, WAIT, TX), given `target_ready` and `target_data_in_valid` each asserted in the first cycle of their state.

## Test plan
- Write: addr 16'hA5C3 and data 8'h3C sent serially with rw=1 → `target_ack` one cycle; one request with addr A5C3, data 3C, `target_rw`=1.
- Read: addr 16'h0010 with rw=0; target returns 8'h96 after 4 cycles → bus shows bits 0,1,1,0,1,0,0,1 on 8 consecutive `bus_data_out_valid` cycles.
- Read timeout with `RD_TIMEOUT`=5 and no `target_data_in_valid` → 8'hFF transmitted starting after 5 wait cycles.
- Backpressure: `target_ready` held low for 10 cycles → `target_req_valid` stays high with stable fields. `bus_init_ready` low 3 cycles mid-TX → exactly 8 bits total, order preserved.
- Abort: 3 data bits, then an address-mode bit → no target request; the new 16-bit address captured correctly.
- Reset at TX bit 4 → next cycle `bus_data`='z, `bus_data_out_valid`=0, state RX_ADDR, and a following write completes normally.

Source files
------------

// File: rtl/target_port.sv
`default_nettype none
// ============================================================================
//  Module      : target_port
//  Description : Serial bus target port. Deserializes address/write data from
//                the one-bit bus, issues target requests, returns read bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module target_port #(
    parameter int RD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire         bus_data,
    input  logic        bus_data_in_valid,
    input  logic        bus_mode,
    input  logic        bus_init_rw,
    input  logic        bus_init_ready,
    output logic        target_ack,
    output logic        bus_data_out_valid,
    output logic [15:0] target_addr_out,
    output logic [7:0]  target_data_out,
    output logic        target_rw,
    output logic        target_req_valid,
    input  logic        target_ready,
    input  logic [7:0]  target_data_in,
    input  logic        target_data_in_valid
);

    localparam logic [2:0] c_RX_ADDR  = 3'd0;
    localparam logic [2:0] c_RX_DATA  = 3'd1;
    localparam logic [2:0] c_WR_ISSUE = 3'd2;
    localparam logic [2:0] c_RD_ISSUE = 3'd3;
    localparam logic [2:0] c_RD_WAIT  = 3'd4;
    localparam logic [2:0] c_TX_DATA  = 3'd5;

    // Last wait-counter value before the read is answered with 8'hFF.
    localparam logic [15:0] c_WAIT_LAST = 16'(RD_TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_wait_cnt;
    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic [7:0]  r_rd_byte;
    logic        r_rw;
    logic        r_req;
    logic        r_ack;
    logic        r_tx_en;
    logic        r_tx_bit;

    logic        w_bit_in;
    logic        w_addr_bit;
    logic        w_data_bit;
    logic [7:0]  w_capture_byte;

    assign w_bit_in       = bus_data;
    assign w_addr_bit     = bus_data_in_valid && !bus_mode;
    assign w_data_bit     = bus_data_in_valid && bus_mode;
    assign w_capture_byte = target_data_in_valid ? target_data_in : 8'hFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_RX_ADDR;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rd_byte  <= '0;
            r_rw       <= 1'b0;
            r_req      <= 1'b0;
            r_ack      <= 1'b0;
            r_tx_en    <= 1'b0;
            r_tx_bit   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                c_RX_ADDR: begin
                    if (w_addr_bit) begin
                        r_addr[r_bit_cnt[3:0]] <= w_bit_in;
                        if (r_bit_cnt == 5'd15) begin
                            r_bit_cnt <= '0;
                            r_ack     <= 1'b1;
                            r_rw      <= bus_init_rw;
                            if (bus_init_rw) begin
                                r_state <= c_RX_DATA;
                            end else begin
                                r_state <= c_RD_ISSUE;
                                r_req   <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end
                c_RX_DATA: begin
                    if (w_data_bit) begin
                        r_data[r_bit_cnt[2:0]] <= w_bit_in;
                        if (r_bit_cnt == 5'd7) begin
                            r_bit_cnt <= '0;
                            r_req     <= 1'b1;
                            r_state   <= c_WR_ISSUE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end else if (w_addr_bit) begin
                        // Abort: this bit starts a fresh address as bit 0.
                        r_addr[0] <= w_bit_in;
                        r_bit_cnt <= 5'd1;
                        r_state   <= c_RX_ADDR;
                    end
                end
                c_WR_ISSUE: begin
                    if (target_ready) begin
                        r_req   <= 1'b0;
                        r_state <= c_RX_ADDR;
                    end
                end
                c_RD_ISSUE: begin
                    if (target_ready) begin
                        r_req      <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= c_RD_WAIT;
                    end
                end
                c_RD_WAIT: begin
                    if (target_data_in_valid || (r_wait_cnt == c_WAIT_LAST)) begin
                        r_rd_byte <= w_capture_byte;
                        r_state   <= c_TX_DATA;
                        if (bus_init_ready) begin
                            r_tx_en   <= 1'b1;
                            r_tx_bit  <= w_capture_byte[0];
                            r_bit_cnt <= 5'd1;
                        end else begin
                            r_tx_en   <= 1'b0;
                            r_bit_cnt <= '0;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                c_TX_DATA: begin
                    // r_bit_cnt counts bits launched; the 8th is on the line now.
                    if (r_bit_cnt == 5'd8) begin
                        r_tx_en   <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= c_RX_ADDR;
                    end else if (bus_init_ready) begin
                        r_tx_en   <= 1'b1;
                        r_tx_bit  <= r_rd_byte[r_bit_cnt[2:0]];
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end else begin
                        r_tx_en <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_RX_ADDR;
                end
            endcase
        end
    end

    assign bus_data           = r_tx_en ? r_tx_bit : 1'bz;
    assign bus_data_out_valid = r_tx_en;
    assign target_ack         = r_ack;
    assign target_addr_out    = r_addr;
    assign target_data_out    = r_data;
    assign target_rw          = r_rw;
    assign target_req_valid   = r_req;

endmodule
`default_nettype wire

// File: tb/tb_target_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_target_port
//  Description : Directed self-checking bench for target_port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_target_port;

    localparam int c_TIMEOUT = 5;

    logic        clk = 1'b0;
    logic        rst;
    wire         bus_data;
    logic        tb_drv_en;
    logic        tb_drv_val;
    logic        bus_data_in_valid;
    logic        bus_mode;
    logic        bus_init_rw;
    logic        bus_init_ready;
    logic        target_ack;
    logic        bus_data_out_valid;
    logic [15:0] target_addr_out;
    logic [7:0]  target_data_out;
    logic        target_rw;
    logic        target_req_valid;
    logic        target_ready;
    logic [7:0]  target_data_in;
    logic        target_data_in_valid;

    int total = 0;
    int bad   = 0;

    assign bus_data = tb_drv_en ? tb_drv_val : 1'bz;

    always #5 clk = ~clk;

    target_port #(.RD_TIMEOUT(c_TIMEOUT)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus_data             (bus_data),
        .bus_data_in_valid    (bus_data_in_valid),
        .bus_mode             (bus_mode),
        .bus_init_rw          (bus_init_rw),
        .bus_init_ready       (bus_init_ready),
        .target_ack           (target_ack),
        .bus_data_out_valid   (bus_data_out_valid),
        .target_addr_out      (target_addr_out),
        .target_data_out      (target_data_out),
        .target_rw            (target_rw),
        .target_req_valid     (target_req_valid),
        .target_ready         (target_ready),
        .target_data_in       (target_data_in),
        .target_data_in_valid (target_data_in_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic mode, input logic b, input logic rw);
        bus_data_in_valid = 1'b1;
        bus_mode          = mode;
        bus_init_rw       = rw;
        tb_drv_en         = 1'b1;
        tb_drv_val        = b;
        tick();
        bus_data_in_valid = 1'b0;
        tb_drv_en         = 1'b0;
    endtask

    task automatic send_addr(input logic [15:0] a, input logic rw);
        for (int i = 0; i < 16; i++) send_bit(1'b0, a[i], rw);
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(1'b1, d[i], 1'b1);
    endtask

    // Gathers up to 8 driven bits; bus_init_ready is low for iterations [s, s+l).
    task automatic collect(input int s, input int l, output logic [7:0] b,
                           output int start, output int nvalid, output int span);
        int n;
        int last;
        n = 0; last = 0; start = -1; b = '0;
        for (int c = 0; c < 80 && n < 8; c++) begin
            if (bus_data_out_valid) begin
                b[n] = bus_data;
                if (start < 0) start = c;
                last = c;
                n++;
            end
            if (n < 8) begin
                bus_init_ready = !(c >= s && c < s + l);
                tick();
            end
        end
        bus_init_ready = 1'b1;
        nvalid = n;
        span   = (start < 0) ? 0 : last - start + 1;
    endtask

    task automatic start_read(input logic [15:0] a);
        send_addr(a, 1'b0);
        target_ready = 1'b1;
        tick();
        target_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        total++; if (target_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%0h exp=0", target_ack); end
        total++; if (bus_data_out_valid !== 1'b0) begin bad++; $display("FAIL rst_oval got=%0h exp=0", bus_data_out_valid); end
        total++; if (target_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", target_req_valid); end
        total++; if (target_rw !== 1'b0) begin bad++; $display("FAIL rst_rw got=%0h exp=0", target_rw); end
        total++; if (target_addr_out !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h exp=0000", target_addr_out); end
        total++; if (target_data_out !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", target_data_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write;
        logic [7:0] d;
        d = 8'h3C;
        send_bit(1'b1, 1'b1, 1'b1);  // data-mode bit in RX_ADDR must be ignored
        send_addr(16'hA5C3, 1'b1);
        total++; if (target_ack !== 1'b1) begin bad++; $display("FAIL wr_ack got=%0h exp=1", target_ack); end
        total++; if (target_addr_out !== 16'hA5C3) begin bad++; $display("FAIL wr_addr_early got=%h exp=a5c3", target_addr_out); end
        send_bit(1'b1, d[0], 1'b1);
        total++; if (target_ack !== 1'b0) begin bad++; $display("FAIL wr_ack_pulse got=%0h exp=0", target_ack); end
        for (int i = 1; i < 8; i++) send_bit(1'b1, d[i], 1'b1);
        total++; if (target_req_valid !== 1'b1) begin bad++; $display("FAIL wr_req got=%0h exp=1", target_req_valid); end
        total++; if (target_rw !== 1'b1) begin bad++; $display("FAIL wr_rw got=%0h exp=1", target_rw); end
        total++; if (target_addr_out !== 16'hA5C3) begin bad++; $display("FAIL wr_addr got=%h exp=a5c3", target_addr_out); end
        total++; if (target_data_out !== 8'h3C) begin bad++; $display("FAIL wr_data got=%h exp=3c", target_data_out); end
        target_ready = 1'b1;
        tick();
        target_ready = 1'b0;
        total++; if (target_req_valid !== 1'b0) begin bad++; $display("FAIL wr_req_drop got=%0h exp=0", target_req_valid); end
        tick();
        total++; if (target_req_valid !== 1'b0) begin bad++; $display("FAIL wr_single_req got=%0h exp=0", target_req_valid); end
    endtask

    task automatic test_read;
        logic [7:0] b;
        int st, nv, sp;
        send_addr(16'h0010, 1'b0);
        total++; if (target_ack !== 1'b1) begin bad++; $display("FAIL rd_ack got=%0h exp=1", target_ack); end
        total++; if (target_req_valid !== 1'b1) begin bad++; $display("FAIL rd_req got=%0h exp=1", target_req_valid); end
        total++; if (target_rw !== 1'b0) begin bad++; $display("FAIL rd_rw got=%0h exp=0", target_rw); end
        target_ready = 1'b1;
        tick();
        target_ready = 1'b0;
        total++; if (target_req_valid !== 1'b0) begin bad++; $display("FAIL rd_req_drop got=%0h exp=0", target_req_valid); end
        repeat (3) tick();
        target_data_in = 8'h96;
        target_data_in_valid = 1'b1;
        tick();
        target_data_in_valid = 1'b0;
        collect(100, 0, b, st, nv, sp);
        total++; if (nv !== 8) begin bad++; $display("FAIL rd_nbits got=%0d exp=8", nv); end
        total++; if (st !== 0) begin bad++; $display("FAIL rd_first got=%0d exp=0", st); end
        total++; if (sp !== 8) begin bad++; $display("FAIL rd_span got=%0d exp=8", sp); end
        total++; if (b !== 8'h96) begin bad++; $display("FAIL rd_byte got=%h exp=96", b); end
        tick();
        total++; if (bus_data_out_valid !== 1'b0) begin bad++; $display("FAIL rd_release got=%0h exp=0", bus_data_out_valid); end
    endtask

    task automatic test_timeout;
        logic [7:0] b;
        int st, nv, sp;
        start_read(16'h7FFF);
        collect(100, 0, b, st, nv, sp);
        total++; if (st !== c_TIMEOUT) begin bad++; $display("FAIL to_first got=%0d exp=%0d", st, c_TIMEOUT); end
        total++; if (b !== 8'hFF) begin bad++; $display("FAIL to_byte got=%h exp=ff", b); end
        total++; if (nv !== 8) begin bad++; $display("FAIL to_nbits got=%0d exp=8", nv); end
        tick();
    endtask

    task automatic test_timeout_tie;
        logic [7:0] b;
        int st, nv, sp;
        start_read(16'h1357);
        repeat (c_TIMEOUT - 1) tick();
        target_data_in = 8'h5A;
        target_data_in_valid = 1'b1;
        tick();
        target_data_in_valid = 1'b0;
        collect(100, 0, b, st, nv, sp);
        total++; if (b !== 8'h5A) begin bad++; $display("FAIL tie_byte got=%h exp=5a", b); end
        total++; if (st !== 0) begin bad++; $display("FAIL tie_first got=%0d exp=0", st); end
        tick();
    endtask

    task automatic test_min_latency;
        logic [7:0] b;
        int st, nv, sp;
        target_ready = 1'b1;
        target_data_in = 8'hC3;
        target_data_in_valid = 1'b1;
        send_addr(16'h4321, 1'b0);
        collect(100, 0, b, st, nv, sp);
        target_ready = 1'b0;
        target_data_in_valid = 1'b0;
        total++; if (st !== 2) begin bad++; $display("FAIL lat_first got=%0d exp=2", st); end
        total++; if (b !== 8'hC3) begin bad++; $display("FAIL lat_byte got=%h exp=c3", b); end
        tick();
    endtask

    task automatic test_backpressure;
        logic [7:0] b;
        int st, nv, sp;
        send_addr(16'h1234, 1'b1);
        send_data(8'h5A);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (target_req_valid !== 1'b1 || target_addr_out !== 16'h1234 ||
                target_data_out !== 8'h5A || target_rw !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got req=%0h addr=%h data=%h rw=%0h exp 1/1234/5a/1",
                         i, target_req_valid, target_addr_out, target_data_out, target_rw);
            end
            tick();
        end
        target_ready = 1'b1;
        tick();
        target_ready = 1'b0;
        total++; if (target_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_drop got=%0h exp=0", target_req_valid); end
        start_read(16'hBEEF);
        target_data_in = 8'hA6;
        target_data_in_valid = 1'b1;
        tick();
        target_data_in_valid = 1'b0;
        collect(3, 3, b, st, nv, sp);
        total++; if (nv !== 8) begin bad++; $display("FAIL stall_nbits got=%0d exp=8", nv); end
        total++; if (sp !== 11) begin bad++; $display("FAIL stall_span got=%0d exp=11", sp); end
        total++; if (b !== 8'hA6) begin bad++; $display("FAIL stall_byte got=%h exp=a6", b); end
        tick();
    endtask

    task automatic test_abort;
        logic [15:0] a;
        a = 16'h8421;
        send_addr(16'h0F0F, 1'b1);
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b0, a[0], 1'b1);
        total++; if (target_req_valid !== 1'b0) begin bad++; $display("FAIL ab_noreq got=%0h exp=0", target_req_valid); end
        for (int i = 1; i < 16; i++) send_bit(1'b0, a[i], 1'b1);
        total++; if (target_ack !== 1'b1) begin bad++; $display("FAIL ab_ack got=%0h exp=1", target_ack); end
        total++; if (target_addr_out !== 16'h8421) begin bad++; $display("FAIL ab_addr got=%h exp=8421", target_addr_out); end
        total++; if (target_req_valid !== 1'b0) begin bad++; $display("FAIL ab_noreq2 got=%0h exp=0", target_req_valid); end
        send_data(8'h77);
        total++; if (target_req_valid !== 1'b1) begin bad++; $display("FAIL ab_req got=%0h exp=1", target_req_valid); end
        total++; if (target_data_out !== 8'h77) begin bad++; $display("FAIL ab_data got=%h exp=77", target_data_out); end
        target_ready = 1'b1;
        tick();
        target_ready = 1'b0;
    endtask

    task automatic test_reset_tx;
        target_ready = 1'b1;
        target_data_in = 8'h5B;
        target_data_in_valid = 1'b1;
        send_addr(16'h2222, 1'b0);
        tick(); tick();
        target_ready = 1'b0;
        target_data_in_valid = 1'b0;
        total++; if (bus_data_out_valid !== 1'b1) begin bad++; $display("FAIL rtx_bit0 got=%0h exp=1", bus_data_out_valid); end
        repeat (4) tick();
        total++; if (bus_data_out_valid !== 1'b1 || bus_data !== 1'b1) begin bad++; $display("FAIL rtx_bit4 got valid=%0h bit=%0h exp 1/1", bus_data_out_valid, bus_data); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus_data_out_valid !== 1'b0) begin bad++; $display("FAIL rtx_release got=%0h exp=0", bus_data_out_valid); end
        total++; if (target_req_valid !== 1'b0 || target_ack !== 1'b0) begin bad++; $display("FAIL rtx_quiet got req=%0h ack=%0h exp 0/0", target_req_valid, target_ack); end
        send_addr(16'h0BAD, 1'b1);
        send_data(8'hE1);
        total++; if (target_req_valid !== 1'b1 || target_addr_out !== 16'h0BAD || target_data_out !== 8'hE1) begin
            bad++; $display("FAIL rtx_write got req=%0h addr=%h data=%h exp 1/0bad/e1", target_req_valid, target_addr_out, target_data_out);
        end
        target_ready = 1'b1;
        tick();
        target_ready = 1'b0;
        total++; if (target_req_valid !== 1'b0) begin bad++; $display("FAIL rtx_req_drop got=%0h exp=0", target_req_valid); end
    endtask

    initial begin
        rst                  = 1'b1;
        tb_drv_en            = 1'b0;
        tb_drv_val           = 1'b0;
        bus_data_in_valid    = 1'b0;
        bus_mode             = 1'b0;
        bus_init_rw          = 1'b0;
        bus_init_ready       = 1'b1;
        target_ready         = 1'b0;
        target_data_in       = 8'h00;
        target_data_in_valid = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_timeout_tie();
        test_min_latency();
        test_backpressure();
        test_abort();
        test_reset_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
